// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the 8-bit data memory; one request in flight at a time.
// Define MEMACC_WIDE_EN to enable 16-bit accesses split into two consecutive byte accesses.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_wide,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic [2*DATA_W-1:0]   rsp_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StIssueLo, StIssueHi, StWait} state_e;

  state_e              state_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_lo_q;
  logic                rsp_valid_q;
  logic [2*DATA_W-1:0] rsp_rdata_q;

`ifdef MEMACC_WIDE_EN
  logic                wide_q;
  logic [DATA_W-1:0]   wdata_hi_q;
  logic [DATA_W-1:0]   rdata_lo_q;
`else
  // Wide request fields have no effect in the narrow-only build.
  logic unused_wide;
  assign unused_wide = ^{req_wide, req_wdata[2*DATA_W-1:DATA_W]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_lo_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MEMACC_WIDE_EN
      wide_q      <= 1'b0;
      wdata_hi_q  <= '0;
      rdata_lo_q  <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q       <= req_we;
            addr_q     <= req_addr;
            wdata_lo_q <= req_wdata[DATA_W-1:0];
`ifdef MEMACC_WIDE_EN
            wide_q     <= req_wide;
            wdata_hi_q <= req_wdata[2*DATA_W-1:DATA_W];
`endif
            state_q    <= StIssueLo;
          end
        end
        StIssueLo: begin
`ifdef MEMACC_WIDE_EN
          if (wide_q)     state_q <= StIssueHi;
          else if (we_q)  state_q <= StIdle;
          else            state_q <= StWait;
`else
          state_q <= we_q ? StIdle : StWait;
`endif
        end
`ifdef MEMACC_WIDE_EN
        StIssueHi: begin
          // Low byte read in StIssueLo arrives now.
          rdata_lo_q <= mem_rdata;
          state_q    <= we_q ? StIdle : StWait;
        end
`endif
        StWait: begin
          rsp_valid_q <= 1'b1;
`ifdef MEMACC_WIDE_EN
          rsp_rdata_q <= wide_q ? {mem_rdata, rdata_lo_q} : {{DATA_W{1'b0}}, mem_rdata};
`else
          rsp_rdata_q <= {{DATA_W{1'b0}}, mem_rdata};
`endif
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StIssueLo: begin
        mem_read  = !we_q;
        mem_write = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_lo_q;
      end
`ifdef MEMACC_WIDE_EN
      StIssueHi: begin
        mem_read  = !we_q;
        mem_write = we_q;
        mem_addr  = addr_q + ADDR_W'(1);
        mem_wdata = wdata_hi_q;
      end
`endif
      default: ;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a one-cycle-latency byte memory model.
// Wide-access steps run only when MEMACC_WIDE_EN is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_wide;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;

  logic [7:0]  mem [256] = '{default: 8'h00};
  int          wr_cnt  = 0;
  int          rd_cnt  = 0;
  int          rsp_cnt = 0;
  int          checks  = 0;
  int          errors  = 0;
  int          wr0, rd0, rsp0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_wide  (req_wide),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (mem_write === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
    if (mem_read === 1'b1) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt    <= rd_cnt + 1;
    end
    if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic wide, input logic [7:0] a,
                       input logic [15:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_wide  = wide;
    req_addr  = a;
    req_wdata = d;
  endtask

  // Runs a store to completion with a bounded wait for the unit to go idle.
  task automatic do_store(input logic wide, input logic [7:0] a, input logic [15:0] d);
    issue(1'b1, wide, a, d);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8 && req_ready !== 1'b1; i++) tick();
    chk("store_idle", {15'd0, req_ready}, 16'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wide  = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
    tick();
    tick();

    // Reset values
    chk("rst_ready",  {15'd0, req_ready}, 16'd1);
    chk("rst_busy",   {15'd0, busy},      16'd0);
    chk("rst_read",   {15'd0, mem_read},  16'd0);
    chk("rst_write",  {15'd0, mem_write}, 16'd0);
    chk("rst_rspv",   {15'd0, rsp_valid}, 16'd0);
    chk("rst_rdata",  rsp_rdata,          16'h0000);
    chk("rst_addr",   {8'd0, mem_addr},   16'h0000);
    chk("rst_wdata",  {8'd0, mem_wdata},  16'h0000);
    rst_n = 1'b1;
    tick();

    // Narrow store 0xA5 -> 0x10
    wr0 = wr_cnt;
    issue(1'b1, 1'b0, 8'h10, 16'h77A5);
    chk("st_ready_c0", {15'd0, req_ready}, 16'd1);
    tick();
    req_valid = 1'b0;
    chk("st_write_c1", {15'd0, mem_write}, 16'd1);
    chk("st_read_c1",  {15'd0, mem_read},  16'd0);
    chk("st_addr_c1",  {8'd0, mem_addr},   16'h0010);
    chk("st_wdata_c1", {8'd0, mem_wdata},  16'h00A5);
    chk("st_busy_c1",  {15'd0, busy},      16'd1);
    tick();
    chk("st_write_c2", {15'd0, mem_write}, 16'd0);
    chk("st_ready_c2", {15'd0, req_ready}, 16'd1);
    chk("st_mem10",    {8'd0, mem[8'h10]}, 16'h00A5);
    chk("st_wrcnt",    16'(wr_cnt - wr0),  16'd1);

    // Narrow load from 0x10
    rsp0 = rsp_cnt;
    issue(1'b0, 1'b0, 8'h10, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("ld_read_c1",  {15'd0, mem_read},  16'd1);
    chk("ld_write_c1", {15'd0, mem_write}, 16'd0);
    chk("ld_addr_c1",  {8'd0, mem_addr},   16'h0010);
    tick();
    chk("ld_read_c2",  {15'd0, mem_read},  16'd0);
    chk("ld_rspv_c2",  {15'd0, rsp_valid}, 16'd0);
    chk("ld_ready_c2", {15'd0, req_ready}, 16'd0);
    chk("ld_addr_c2",  {8'd0, mem_addr},   16'h0000);
    tick();
    chk("ld_rspv_c3",  {15'd0, rsp_valid}, 16'd1);
    chk("ld_rdata_c3", rsp_rdata,          16'h00A5);
    chk("ld_ready_c3", {15'd0, req_ready}, 16'd1);
    tick();
    chk("ld_rspv_c4",  {15'd0, rsp_valid}, 16'd0);
    chk("ld_hold_c4",  rsp_rdata,          16'h00A5);
    chk("ld_rspcnt",   16'(rsp_cnt - rsp0), 16'd1);

    // Busy hold-off: second load held on req_valid through the first
    do_store(1'b0, 8'h30, 16'h0011);
    do_store(1'b0, 8'h31, 16'h0022);
    rd0  = rd_cnt;
    rsp0 = rsp_cnt;
    issue(1'b0, 1'b0, 8'h30, 16'h0000);
    tick();
    issue(1'b0, 1'b0, 8'h31, 16'h0000);
    chk("bo_addr_c1",  {8'd0, mem_addr},   16'h0030);
    chk("bo_ready_c1", {15'd0, req_ready}, 16'd0);
    tick();
    chk("bo_read_c2",  {15'd0, mem_read},  16'd0);
    chk("bo_ready_c2", {15'd0, req_ready}, 16'd0);
    tick();
    chk("bo_ready_c3", {15'd0, req_ready}, 16'd1);
    chk("bo_rspv_c3",  {15'd0, rsp_valid}, 16'd1);
    chk("bo_rdata_c3", rsp_rdata,          16'h0011);
    tick();
    req_valid = 1'b0;
    chk("bo_read_c4",  {15'd0, mem_read},  16'd1);
    chk("bo_addr_c4",  {8'd0, mem_addr},   16'h0031);
    chk("bo_rspv_c4",  {15'd0, rsp_valid}, 16'd0);
    tick();
    tick();
    chk("bo_rspv_c6",  {15'd0, rsp_valid}, 16'd1);
    chk("bo_rdata_c6", rsp_rdata,          16'h0022);
    tick();
    tick();
    chk("bo_rdcnt",    16'(rd_cnt - rd0),   16'd2);
    chk("bo_rspcnt",   16'(rsp_cnt - rsp0), 16'd2);

`ifdef MEMACC_WIDE_EN
    // Wide store 0xBEEF at 0xFF wraps to 0x00
    issue(1'b1, 1'b1, 8'hFF, 16'hBEEF);
    tick();
    req_valid = 1'b0;
    chk("ws_write_c1", {15'd0, mem_write}, 16'd1);
    chk("ws_addr_c1",  {8'd0, mem_addr},   16'h00FF);
    chk("ws_wdata_c1", {8'd0, mem_wdata},  16'h00EF);
    tick();
    chk("ws_write_c2", {15'd0, mem_write}, 16'd1);
    chk("ws_addr_c2",  {8'd0, mem_addr},   16'h0000);
    chk("ws_wdata_c2", {8'd0, mem_wdata},  16'h00BE);
    chk("ws_ready_c2", {15'd0, req_ready}, 16'd0);
    tick();
    chk("ws_ready_c3", {15'd0, req_ready}, 16'd1);
    chk("ws_write_c3", {15'd0, mem_write}, 16'd0);
    chk("ws_memff",    {8'd0, mem[8'hFF]}, 16'h00EF);
    chk("ws_mem00",    {8'd0, mem[8'h00]}, 16'h00BE);

    // Wide load from 0xFF
    issue(1'b0, 1'b1, 8'hFF, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("wl_read_c1",  {15'd0, mem_read},  16'd1);
    chk("wl_addr_c1",  {8'd0, mem_addr},   16'h00FF);
    tick();
    chk("wl_read_c2",  {15'd0, mem_read},  16'd1);
    chk("wl_addr_c2",  {8'd0, mem_addr},   16'h0000);
    tick();
    chk("wl_rspv_c3",  {15'd0, rsp_valid}, 16'd0);
    chk("wl_busy_c3",  {15'd0, busy},      16'd1);
    tick();
    chk("wl_rspv_c4",  {15'd0, rsp_valid}, 16'd1);
    chk("wl_rdata_c4", rsp_rdata,          16'hBEEF);
    chk("wl_ready_c4", {15'd0, req_ready}, 16'd1);
    tick();
`else
    // Narrow-only build: wide request behaves as a byte access
    do_store(1'b0, 8'h20, 16'h005A);
    do_store(1'b0, 8'h21, 16'h0077);
    rd0 = rd_cnt;
    issue(1'b0, 1'b1, 8'h20, 16'h0000);
    tick();
    req_valid = 1'b0;
    chk("nw_read_c1",  {15'd0, mem_read},  16'd1);
    chk("nw_addr_c1",  {8'd0, mem_addr},   16'h0020);
    tick();
    chk("nw_read_c2",  {15'd0, mem_read},  16'd0);
    tick();
    chk("nw_rspv_c3",  {15'd0, rsp_valid}, 16'd1);
    chk("nw_rdata_c3", rsp_rdata,          16'h005A);
    chk("nw_rdcnt",    16'(rd_cnt - rd0),  16'd1);
    tick();
    wr0 = wr_cnt;
    do_store(1'b1, 8'h50, 16'hBEEF);
    chk("nw_wrcnt",    16'(wr_cnt - wr0),  16'd1);
    chk("nw_mem50",    {8'd0, mem[8'h50]}, 16'h00EF);
    chk("nw_mem51",    {8'd0, mem[8'h51]}, 16'h0000);
`endif

    // Reset during the first store cycle: nothing gets written
    issue(1'b1, 1'b1, 8'h40, 16'h1234);
    tick();
    req_valid = 1'b0;
    chk("rm_write_c1", {15'd0, mem_write}, 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_write_drop", {15'd0, mem_write}, 16'd0);
    chk("rm_addr_drop",  {8'd0, mem_addr},   16'h0000);
    chk("rm_ready_drop", {15'd0, req_ready}, 16'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rm_busy_idle", {15'd0, busy},       16'd0);
    chk("rm_mem40",     {8'd0, mem[8'h40]},  16'h0000);
    chk("rm_mem41",     {8'd0, mem[8'h41]},  16'h0000);
    chk("rm_rspv",      {15'd0, rsp_valid},  16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
